noise64_checker: RTL and testbench

NOISE64_CHECKER -- requirements
Module: noise64_checker

---
 rtl/noise64_checker.sv | 141 ++++++++++++++
 tb/tb_noise64_checker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/noise64_checker.sv
// noise64_checker: locks onto a 64-bit LFSR noise generator from its raw 18-bit samples and counts mismatches.
// Define NOISE64_CHK_BITERR_EN to build the per-bit error counter; otherwise bit_err_count is tied to 0.
module noise64_checker (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [17:0] in,
  input  logic        clr,
  output logic        locked,
  output logic        err,
  output logic        ovr,
  output logic [15:0] err_count,
  output logic [23:0] bit_err_count
);
  // state | meaning
  // HUNT  | gathering samples into seed until a nonzero 64-bit seed is formed
  // ADV   | stepping sr one bit per clock, 18 times, to the next sample
  // TRACK | waiting for the next sample to compare against sr[17:0]
  typedef enum logic [1:0] {HUNT = 2'd0, ADV = 2'd1, TRACK = 2'd2} state_t;

  state_t      r_state, w_next;
  logic [63:0] r_seed, r_sr;
  logic [1:0]  r_fill_cnt, r_miss_cnt;
  logic [4:0]  r_adv_cnt;
  logic        r_err, r_ovr;
  logic [15:0] r_err_count;

  logic [63:0] w_seed_new;
  logic        w_mismatch, w_lose, w_fb, w_count_err;

  assign w_seed_new  = {r_seed[45:0], in};
  assign w_mismatch  = (in != r_sr[17:0]);
  assign w_lose      = w_mismatch && (r_miss_cnt == 2'd2);
  assign w_fb        = r_sr[63] ^ r_sr[62] ^ r_sr[60] ^ r_sr[59];
  assign w_count_err = (r_state == TRACK) && ena && w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HUNT:    if (ena && (r_fill_cnt == 2'd3) && (w_seed_new != 64'd0)) w_next = ADV;
      ADV:     if (ena) w_next = HUNT;
               else if (r_adv_cnt == 5'd0) w_next = TRACK;
      TRACK:   if (ena) w_next = w_lose ? HUNT : ADV;
      default: w_next = HUNT;
    endcase
  end

  always_comb begin
    locked    = (r_state != HUNT);
    err       = r_err;
    ovr       = r_ovr;
    err_count = r_err_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed     <= 64'd0;
      r_sr       <= 64'd0;
      r_fill_cnt <= 2'd0;
      r_miss_cnt <= 2'd0;
      r_adv_cnt  <= 5'd0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      r_ovr <= 1'b0;
      case (r_state)
        HUNT: if (ena) begin
          r_seed <= w_seed_new;
          if (r_fill_cnt != 2'd3) r_fill_cnt <= r_fill_cnt + 2'd1;
          if (w_next == ADV) begin
            r_sr      <= w_seed_new;
            r_adv_cnt <= 5'd17;
          end
        end
        ADV: if (ena) begin
          // sample arrived before sr caught up: drop it and reacquire
          r_ovr      <= 1'b1;
          r_fill_cnt <= 2'd0;
          r_miss_cnt <= 2'd0;
        end else begin
          r_sr <= {r_sr[62:0], w_fb};
          if (r_adv_cnt != 5'd0) r_adv_cnt <= r_adv_cnt - 5'd1;
        end
        TRACK: if (ena) begin
          r_adv_cnt <= 5'd17;
          if (w_mismatch) begin
            r_err <= 1'b1;
            if (w_lose) begin
              r_miss_cnt <= 2'd0;
              r_fill_cnt <= 2'd0;
            end else begin
              r_miss_cnt <= r_miss_cnt + 2'd1;
            end
          end else begin
            r_miss_cnt <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                        r_err_count <= 16'd0;
    else if (clr)                                   r_err_count <= 16'd0;
    else if (w_count_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
  end

`ifdef NOISE64_CHK_BITERR_EN
  logic [17:0] w_diff;
  logic [4:0]  w_pop;
  logic [24:0] w_bit_sum;
  logic [23:0] r_bit_err_count;

  assign w_diff = in ^ r_sr[17:0];

  always_comb begin
    w_pop = 5'd0;
    for (int i = 0; i < 18; i++) w_pop = w_pop + {4'd0, w_diff[i]};
  end

  assign w_bit_sum = {1'b0, r_bit_err_count} + {20'd0, w_pop};

  always_ff @(posedge clk) begin
    if (rst)              r_bit_err_count <= 24'd0;
    else if (clr)         r_bit_err_count <= 24'd0;
    else if (w_count_err) r_bit_err_count <= w_bit_sum[24] ? 24'hFFFFFF : w_bit_sum[23:0];
  end

  assign bit_err_count = r_bit_err_count;
`else
  assign bit_err_count = 24'd0;
`endif

endmodule

// File: tb/tb_noise64_checker.sv
// Scoreboard bench for noise64_checker: a reference LFSR generator drives samples, expected err/ovr pulses are queued.
module tb_noise64_checker;
  logic        clk = 1'b0;
  logic        rst, ena, clr;
  logic [17:0] in;
  logic        locked, err, ovr;
  logic [15:0] err_count;
  logic [23:0] bit_err_count;

  noise64_checker dut (
    .clk(clk), .rst(rst), .ena(ena), .in(in), .clr(clr),
    .locked(locked), .err(err), .ovr(ovr),
    .err_count(err_count), .bit_err_count(bit_err_count)
  );

  always #5 clk = ~clk;

`ifdef NOISE64_CHK_BITERR_EN
  localparam bit BITERR = 1'b1;
`else
  localparam bit BITERR = 1'b0;
`endif

  typedef struct packed {
    logic        is_ovr;
    logic [15:0] cnt;
    logic [23:0] bits;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int          n_err_pulse = 0;
  int          p0;
  logic [63:0] gen;
  logic [15:0] exp_err;
  logic [23:0] exp_bit;
  logic        lk_after;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] adv18(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < 18; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    return t;
  endfunction

  // kind: 0 no pulse, 1 err pulse, 2 ovr pulse. Called on a falling edge; returns gap clocks later.
  task automatic send(input logic [17:0] mask, input int kind, input logic do_clr, input int gap);
    ev_t e;
    ena = 1'b1;
    clr = do_clr;
    in  = gen[17:0] ^ mask;
    gen = adv18(gen);
    if (do_clr) begin
      exp_err = 16'd0;
      exp_bit = 24'd0;
    end else if (kind == 1) begin
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
      if (BITERR) exp_bit = exp_bit + 24'($countones(mask));
    end
    if (kind != 0) begin
      e.is_ovr = (kind == 2);
      e.cnt    = exp_err;
      e.bits   = exp_bit;
      exp_q.push_back(e);
    end
    @(negedge clk);
    ena = 1'b0;
    clr = 1'b0;
    in  = 18'd0;
    lk_after = locked;
    repeat (gap - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (err) n_err_pulse++;
    if (err || ovr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got err=%0b ovr=%0b, required no pulse", err, ovr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind_ovr", {63'd0, ovr}, {63'd0, mon_e.is_ovr});
        chk("pulse_err_count", {48'd0, err_count}, {48'd0, mon_e.cnt});
        chk("pulse_bit_err_count", {40'd0, bit_err_count}, {40'd0, mon_e.bits});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; clr = 1'b0; in = 18'd0;
    exp_err = 16'd0; exp_bit = 24'd0; lk_after = 1'b0;
    gen = 64'h461B87AA9928112E;
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_bit_err_count", bit_err_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // acquisition
    for (int i = 0; i < 3; i++) send(18'd0, 0, 1'b0, 20);
    chk("hunt_not_locked", locked, 0);
    send(18'd0, 0, 1'b0, 20);
    chk("lock_after_4th", lk_after, 1);

    p0 = n_err_pulse;
    for (int i = 0; i < 1000; i++) send(18'd0, 0, 1'b0, 20);
    chk("clean_err_pulses", p0 == n_err_pulse, 1);
    chk("clean_err_count", err_count, 0);
    chk("clean_locked", locked, 1);

    // single corruption
    send(18'h00001, 1, 1'b0, 20);
    send(18'd0, 0, 1'b0, 20);
    send(18'd0, 0, 1'b0, 20);
    chk("single_err_count", err_count, 16'd1);
    chk("single_bit_err_count", bit_err_count, BITERR ? 24'd1 : 24'd0);
    chk("single_locked", locked, 1);

    // clear, then loss of lock
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_err = 16'd0; exp_bit = 24'd0;
    chk("clr_err_count", err_count, 0);
    chk("clr_bit_err_count", bit_err_count, 0);
    send(18'h00003, 1, 1'b0, 20);
    send(18'h30000, 1, 1'b0, 20);
    chk("locked_after_two_misses", locked, 1);
    send(18'h2AAAA, 1, 1'b0, 20);
    chk("unlock_after_third", lk_after, 0);
    chk("loss_err_count", err_count, 16'd3);
    chk("loss_bit_err_count", bit_err_count, BITERR ? 24'd13 : 24'd0);
    for (int i = 0; i < 3; i++) send(18'd0, 0, 1'b0, 20);
    chk("relock_not_yet", locked, 0);
    send(18'd0, 0, 1'b0, 20);
    chk("relock_after_4", lk_after, 1);
    send(18'd0, 0, 1'b0, 20);
    send(18'd0, 0, 1'b0, 20);
    chk("relock_err_count", err_count, 16'd3);

    // overrun: next ena 10 clocks after a tracked one
    send(18'd0, 0, 1'b0, 10);
    send(18'd0, 2, 1'b0, 20);
    chk("ovr_unlock", lk_after, 0);
    chk("ovr_err_count", err_count, 16'd3);
    for (int i = 0; i < 4; i++) send(18'd0, 0, 1'b0, 20);
    chk("ovr_relock", lk_after, 1);
    send(18'd0, 0, 1'b0, 20);
    send(18'd0, 0, 1'b0, 20);
    chk("ovr_relock_err_count", err_count, 16'd3);

    // reset in the middle of ADV
    send(18'd0, 0, 1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 16'd0; exp_bit = 24'd0;
    chk("rst_mid_adv_locked", locked, 0);
    chk("rst_mid_adv_err_count", err_count, 0);

    // all-zero seed never locks
    for (int i = 0; i < 6; i++) begin
      ena = 1'b1; in = 18'd0;
      @(negedge clk);
      ena = 1'b0;
      chk("zero_seed_locked", locked, 0);
      @(negedge clk);
    end

    // saturation and clear
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(18'd0, 0, 1'b0, 20);
    chk("sat_lock", lk_after, 1);
    send(18'd0, 0, 1'b0, 20);
    dut.r_err_count = 16'hFFFD;
    exp_err = 16'hFFFD;
    send(18'h00100, 1, 1'b0, 20);
    send(18'h00100, 1, 1'b0, 20);
    send(18'h00100, 1, 1'b0, 20);
    chk("sat_err_count", err_count, 16'hFFFF);
    chk("sat_unlock", locked, 0);
    for (int i = 0; i < 4; i++) send(18'd0, 0, 1'b0, 20);
    send(18'd0, 0, 1'b0, 20);
    chk("sat_relocked", locked, 1);
    p0 = n_err_pulse;
    send(18'h00005, 1, 1'b1, 20);
    chk("clr_coincident_err_pulse", n_err_pulse - p0, 1);
    chk("clr_coincident_err_count", err_count, 0);
    chk("clr_coincident_bit_err_count", bit_err_count, 0);
    send(18'd0, 0, 1'b0, 20);
    chk("final_locked", locked, 1);
    chk("missing_pulses", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
